// File: rtl/pipeif_fetch.sv
// IF stage and IF/ID register: PC, next-PC select, and req/ready instruction fetch for the 5-stage pipeline.
// Define PIPEIF_FLUSH_EN to squash the delay slot (redirected fetches load a NOP into IF/ID).
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic [1:0]  pcsource,
    input  logic        wpcir,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    typedef enum logic [0:0] {FETCH, HELD} state_t;

    state_t      state, state_next;
    logic [31:0] inst_buf, redir_pc;
    logic        buf_valid, redir_valid;

    logic [31:0] pc_next, dpc4_next, inst_next, inst_buf_next, redir_pc_next;
    logic        buf_valid_next, redir_valid_next, req_next;
    logic [31:0] pc4, target, npc, fetched;
    logic        redirect, done, advance;

    assign imem_addr = pc;

    // State and IF/ID register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            dpc4        <= 32'h0000_0000;
            inst        <= NOP_INST;
            inst_buf    <= NOP_INST;
            buf_valid   <= 1'b0;
            redir_pc    <= 32'h0000_0000;
            redir_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            dpc4        <= dpc4_next;
            inst        <= inst_next;
            inst_buf    <= inst_buf_next;
            buf_valid   <= buf_valid_next;
            redir_pc    <= redir_pc_next;
            redir_valid <= redir_valid_next;
            imem_req    <= req_next;
        end
    end

    // Next-PC select, fetch handshake and IF/ID update
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        dpc4_next        = dpc4;
        inst_next        = inst;
        inst_buf_next    = inst_buf;
        buf_valid_next   = buf_valid;
        redir_pc_next    = redir_pc;
        redir_valid_next = redir_valid;
        advance          = 1'b0;
        fetched          = imem_rdata;

        pc4 = pc + 32'd4;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = rpc;
            2'b11:   target = jpc;
            default: target = pc4;
        endcase
        redirect = wpcir && (pcsource != 2'b00);
        done     = imem_req && imem_ready;

        // A fresh ID redirect wins over a target latched during wait states
        if (redirect)         npc = target;
        else if (redir_valid) npc = redir_pc;
        else                  npc = pc4;

        case (state)
            FETCH: begin
                if (done && wpcir) begin
                    advance = 1'b1;
                end else if (done) begin
                    inst_buf_next  = imem_rdata;
                    buf_valid_next = 1'b1;
                    state_next     = HELD;
                end else if (wpcir) begin
                    inst_next = NOP_INST;
                end
            end
            HELD: begin
                if (wpcir) begin
                    advance        = 1'b1;
                    fetched        = inst_buf;
                    buf_valid_next = 1'b0;
                    state_next     = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase

        if (advance) begin
            dpc4_next        = pc4;
            pc_next          = npc;
            redir_valid_next = 1'b0;
`ifdef PIPEIF_FLUSH_EN
            inst_next = (redirect || redir_valid) ? NOP_INST : fetched;
`else
            inst_next = fetched;
`endif
        end else if (redirect) begin
            // Keep the target alive after the branch has left ID
            redir_pc_next    = target;
            redir_valid_next = 1'b1;
        end

        req_next = (state_next == FETCH);
    end

endmodule
